// File: rtl/bus_arbiter_pkg.sv
// ============================================================================
// Module  : bus_arbiter_pkg
// Brief   : Shared types and constants for the round-robin bus arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    ACTIVE  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int MAX_REQ               = 8;
  localparam int DEFAULT_BEGIN_TIMEOUT = 16;
  localparam int DEFAULT_END_TIMEOUT   = 1024;
  localparam int GRANT_ID_W            = $clog2(MAX_REQ);

endpackage

`default_nettype wire

// File: rtl/bus_arbiter_rr_priority_picker.sv
// ============================================================================
// Module  : rr_priority_picker
// Brief   : Combinational round-robin pick: first set request at or after ptr.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_priority_picker
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]    i_requests,
  input  logic [GRANT_ID_W-1:0] i_prio_ptr,
  output logic [NUM_REQ-1:0]    o_winner_onehot,
  output logic [GRANT_ID_W-1:0] o_winner_id,
  output logic                  o_valid
);

  localparam logic [GRANT_ID_W:0] c_NUM = (GRANT_ID_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] w_dbl;
  logic [NUM_REQ-1:0]   w_rot;
  logic [GRANT_ID_W:0]  w_sum;

  always_comb begin
    // Bit i of the rotated vector is request (ptr + i) mod NUM_REQ.
    w_dbl           = {i_requests, i_requests} >> i_prio_ptr;
    w_rot           = w_dbl[NUM_REQ-1:0];
    w_sum           = '0;
    o_valid         = 1'b0;
    o_winner_id     = '0;
    o_winner_onehot = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        o_valid = 1'b1;
        w_sum   = {1'b0, i_prio_ptr} + (GRANT_ID_W+1)'(i);
      end
    end
    if (w_sum >= c_NUM) begin
      w_sum = w_sum - c_NUM;
    end
    o_winner_id = w_sum[GRANT_ID_W-1:0];
    for (int j = 0; j < NUM_REQ; j++) begin
      o_winner_onehot[j] = o_valid && (o_winner_id == GRANT_ID_W'(j));
    end
  end

endmodule

`default_nettype wire

// File: rtl/bus_arbiter.sv
// ============================================================================
// Module  : bus_arbiter
// Brief   : Round-robin arbiter for the shared burst bus with begin/end watchdog.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int BEGIN_TIMEOUT = DEFAULT_BEGIN_TIMEOUT,
  parameter int END_TIMEOUT   = DEFAULT_END_TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    requestTransaction,
  output logic [NUM_REQ-1:0]    transactionGranted,
  input  logic                  beginTransactionIn,
  input  logic                  endTransactionIn,
  output logic                  endTransactionOut,
  output logic                  busErrorOut,
  output logic                  busIdle,
  output logic [GRANT_ID_W-1:0] grantedId
);

  localparam int                    c_CNT_W      = $clog2(END_TIMEOUT);
  localparam logic [c_CNT_W-1:0]    c_BEGIN_LAST = c_CNT_W'(BEGIN_TIMEOUT - 1);
  localparam logic [c_CNT_W-1:0]    c_END_LAST   = c_CNT_W'(END_TIMEOUT - 1);
  localparam logic [GRANT_ID_W-1:0] c_LAST_ID    = GRANT_ID_W'(NUM_REQ - 1);

  state_t                  r_state;
  state_t                  w_next_state;
  logic [c_CNT_W-1:0]      r_count;
  logic [GRANT_ID_W-1:0]   r_prio_ptr;
  logic [NUM_REQ-1:0]      r_grant;
  logic [GRANT_ID_W-1:0]   r_granted_id;
  logic                    r_end_out;
  logic                    r_bus_error;
  logic                    r_bus_idle;

  logic [NUM_REQ-1:0]      w_win_onehot;
  logic [GRANT_ID_W-1:0]   w_win_id;
  logic                    w_win_valid;
  logic                    w_grantee_req;
  logic                    w_do_grant;
  logic                    w_abort;
  logic [NUM_REQ-1:0]      w_grant_next;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .i_requests      (requestTransaction),
    .i_prio_ptr      (r_prio_ptr),
    .o_winner_onehot (w_win_onehot),
    .o_winner_id     (w_win_id),
    .o_valid         (w_win_valid)
  );

  assign w_grantee_req = |(requestTransaction & r_grant);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_next_state != r_state) begin
        r_count <= '0;
      end else if (r_state == GRANTED || r_state == ACTIVE) begin
        r_count <= r_count + 1'b1;
      end else begin
        r_count <= '0;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_win_valid) w_next_state = GRANTED;
      GRANTED: begin
        if (beginTransactionIn && endTransactionIn) w_next_state = RELEASE;
        else if (beginTransactionIn)                w_next_state = ACTIVE;
        else if (!w_grantee_req || r_count == c_BEGIN_LAST) w_next_state = IDLE;
      end
      ACTIVE:  if (endTransactionIn || r_count == c_END_LAST) w_next_state = RELEASE;
      RELEASE: w_next_state = w_win_valid ? GRANTED : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // A real end arriving on the expiry cycle takes precedence over the abort.
  always_comb begin
    w_do_grant   = (r_state == IDLE || r_state == RELEASE) && w_win_valid;
    w_abort      = (r_state == ACTIVE) && !endTransactionIn && (r_count == c_END_LAST);
    w_grant_next = '0;
    if (w_do_grant) begin
      w_grant_next = w_win_onehot;
    end else if (w_next_state == GRANTED || w_next_state == ACTIVE) begin
      w_grant_next = r_grant;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_grant      <= '0;
      r_granted_id <= '0;
      r_prio_ptr   <= '0;
      r_end_out    <= 1'b0;
      r_bus_error  <= 1'b0;
      r_bus_idle   <= 1'b1;
    end else begin
      r_grant     <= w_grant_next;
      r_end_out   <= w_abort;
      r_bus_error <= w_abort;
      r_bus_idle  <= (w_next_state == IDLE);
      if (w_do_grant) begin
        r_granted_id <= w_win_id;
        r_prio_ptr   <= (w_win_id == c_LAST_ID) ? '0 : w_win_id + 1'b1;
      end
    end
  end

  assign transactionGranted = r_grant;
  assign grantedId          = r_granted_id;
  assign endTransactionOut  = r_end_out;
  assign busErrorOut        = r_bus_error;
  assign busIdle            = r_bus_idle;

endmodule

`default_nettype wire

// File: tb/tb_bus_arbiter.sv
// ============================================================================
// Module  : tb_bus_arbiter
// Brief   : Self-checking bench for bus_arbiter against a transaction-level model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int BT = 16;
  localparam int ET = 1024;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [N-1:0] req   = '0;
  logic         beg   = 1'b0;
  logic         endi  = 1'b0;
  logic [N-1:0] transactionGranted;
  logic         endTransactionOut;
  logic         busErrorOut;
  logic         busIdle;
  logic [2:0]   grantedId;

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus, whether its transaction began, turnaround flag.
  int m_owner = -1;
  bit m_active = 0;
  bit m_turn = 0;
  int m_age = 0;
  int m_ptr = 0;
  int m_gid = 0;
  bit m_end = 0;
  bit m_err = 0;

  bus_arbiter #(.NUM_REQ(N), .BEGIN_TIMEOUT(BT), .END_TIMEOUT(ET)) dut (
    .clock              (clock),
    .reset              (reset),
    .requestTransaction (req),
    .transactionGranted (transactionGranted),
    .beginTransactionIn (beg),
    .endTransactionIn   (endi),
    .endTransactionOut  (endTransactionOut),
    .busErrorOut        (busErrorOut),
    .busIdle            (busIdle),
    .grantedId          (grantedId)
  );

  always #5 clock = ~clock;

  function automatic logic [N+5:0] obs_vec();
    return {transactionGranted, busIdle, grantedId, endTransactionOut, busErrorOut};
  endfunction

  function automatic logic [N+5:0] exp_vec();
    logic [N-1:0] g;
    g = (m_owner >= 0) ? N'(1 << m_owner) : '0;
    return {g, (m_owner < 0 && !m_turn), 3'(m_gid), m_end, m_err};
  endfunction

  task automatic cycle();
    int w;
    @(posedge clock);
    m_end = 0;
    m_err = 0;
    if (!reset) begin
      m_owner = -1; m_active = 0; m_turn = 0; m_age = 0; m_ptr = 0; m_gid = 0;
    end else if (m_owner < 0) begin
      w = -1;
      for (int i = 0; i < N; i++)
        if (w < 0 && req[(m_ptr + i) % N]) w = (m_ptr + i) % N;
      m_turn = 0;
      if (w >= 0) begin
        m_owner = w; m_active = 0; m_age = 0; m_gid = w; m_ptr = (w + 1) % N;
      end
    end else if (!m_active) begin
      if (beg) begin
        if (endi) begin m_owner = -1; m_turn = 1; end
        else begin m_active = 1; m_age = 0; end
      end else if (!req[m_owner] || m_age == BT - 1) begin
        m_owner = -1; m_turn = 0;
      end else begin
        m_age++;
      end
    end else begin
      if (endi) begin
        m_owner = -1; m_turn = 1; m_active = 0;
      end else if (m_age == ET - 1) begin
        m_owner = -1; m_turn = 1; m_active = 0; m_end = 1; m_err = 1;
      end else begin
        m_age++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; beg = 1'b0; endi = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs_vec() !== {4'b0000, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got %b want %b", obs_vec(), {4'b0000, 1'b1, 3'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_single_request();
    do_reset();
    req = 4'b0100;
    cycle();
    checks++;
    if (transactionGranted !== 4'b0100 || grantedId !== 3'd2 || busIdle !== 1'b0) begin
      errors++;
      $display("FAIL single_grant got g=%b id=%0d idle=%b want g=0100 id=2 idle=0",
               transactionGranted, grantedId, busIdle);
    end
    cycle();
    beg = 1'b1; cycle(); beg = 1'b0; req = '0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (transactionGranted !== 4'b0100) begin
        errors++;
        $display("FAIL single_hold got %b want 0100", transactionGranted);
      end
    end
    endi = 1'b1; cycle(); endi = 1'b0;
    checks++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b0) begin
      errors++;
      $display("FAIL single_release got g=%b idle=%b want g=0000 idle=0", transactionGranted, busIdle);
    end
    cycle();
    checks++;
    if (busIdle !== 1'b1 || grantedId !== 3'd2 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL single_idle got idle=%b id=%0d want idle=1 id=2", busIdle, grantedId);
    end
  endtask

  task automatic test_round_robin();
    int order[$];
    int gap = 0;
    int k = -1;
    logic [N-1:0] prev = '0;
    do_reset();
    req = 4'b1111;
    for (int c = 0; c < 80 && order.size() < 5; c++) begin
      beg  = (k == 0);
      endi = (k == 2);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL rr_model got %b want %b", obs_vec(), exp_vec());
      end
      if (transactionGranted != 0 && prev == 0) begin
        for (int j = 0; j < N; j++) if (transactionGranted[j]) order.push_back(j);
        if (order.size() > 1) begin
          checks++;
          if (gap != 1) begin
            errors++;
            $display("FAIL rr_gap got %0d want 1", gap);
          end
        end
        k = 0; gap = 0;
      end else if (transactionGranted != 0) begin
        k++;
      end else begin
        gap++; k = -1;
      end
      prev = transactionGranted;
    end
    beg = 1'b0; endi = 1'b0;
    checks++;
    if (order.size() != 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 ||
        order[3] != 3 || order[4] != 0) begin
      errors++;
      $display("FAIL rr_order got %p want 0 1 2 3 0", order);
    end
  endtask

  task automatic test_begin_timeout();
    int hi = 0;
    bit err_seen = 0;
    do_reset();
    req = 4'b0110;
    cycle();
    while (transactionGranted == 4'b0010 && hi < 40) begin
      hi++;
      if (busErrorOut) err_seen = 1;
      cycle();
    end
    checks++;
    if (hi != BT || err_seen || busErrorOut) begin
      errors++;
      $display("FAIL begin_timeout got cycles=%0d err=%b want cycles=%0d err=0", hi, err_seen, BT);
    end
    cycle();
    checks++;
    if (transactionGranted !== 4'b0100 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL timeout_next got %b want 0100", transactionGranted);
    end
  endtask

  task automatic test_hang_abort();
    int n = 0;
    int width = 0;
    do_reset();
    req = 4'b0001;
    cycle();
    beg = 1'b1; cycle(); beg = 1'b0; req = '0;
    while (!busErrorOut && n < ET + 50) begin
      cycle(); n++;
    end
    checks++;
    if (n != ET || !endTransactionOut || transactionGranted !== 4'b0000 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL hang_abort got n=%0d end=%b g=%b want n=%0d end=1 g=0000",
               n, endTransactionOut, transactionGranted, ET);
    end
    req = 4'b0011;
    while (busErrorOut && width < 5) begin
      width++; cycle();
    end
    checks++;
    if (width != 1 || endTransactionOut || transactionGranted !== 4'b0010) begin
      errors++;
      $display("FAIL abort_pulse got width=%0d g=%b want width=1 g=0010", width, transactionGranted);
    end
  endtask

  task automatic test_withdraw();
    do_reset();
    req = 4'b0100; cycle();
    req = '0; cycle();
    checks++;
    if (transactionGranted !== 4'b0000 || busIdle !== 1'b1) begin
      errors++;
      $display("FAIL withdraw_granted got g=%b idle=%b want g=0000 idle=1", transactionGranted, busIdle);
    end
    req = 4'b0100; cycle();
    beg = 1'b1; cycle(); beg = 1'b0; req = '0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (transactionGranted !== 4'b0100 || obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL withdraw_active got %b want 0100", transactionGranted);
      end
    end
    endi = 1'b1; cycle(); endi = 1'b0;
    checks++;
    if (transactionGranted !== 4'b0000) begin
      errors++;
      $display("FAIL withdraw_end got %b want 0000", transactionGranted);
    end
  endtask

  task automatic test_reset_mid_active();
    do_reset();
    req = 4'b0001; cycle();
    beg = 1'b1; cycle(); beg = 1'b0;
    reset = 1'b0; cycle(); reset = 1'b1;
    checks++;
    if (obs_vec() !== {4'b0000, 1'b1, 3'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid got %b want %b", obs_vec(), {4'b0000, 1'b1, 3'd0, 1'b0, 1'b0});
    end
    req = 4'b1000; cycle();
    checks++;
    if (transactionGranted !== 4'b1000 || grantedId !== 3'd3) begin
      errors++;
      $display("FAIL reset_regrant got g=%b id=%0d want g=1000 id=3", transactionGranted, grantedId);
    end
    req = 4'b1011;
    beg = 1'b1; endi = 1'b1; cycle(); beg = 1'b0; endi = 1'b0;
    cycle();
    checks++;
    if (transactionGranted !== 4'b0001 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL reset_ptr got %b want 0001", transactionGranted);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom);
      beg  = ($urandom_range(0, 3) == 0);
      endi = ($urandom_range(0, 4) == 0);
      cycle();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random c=%0d got %b want %b", c, obs_vec(), exp_vec());
      end
    end
    beg = 1'b0; endi = 1'b0; req = '0;
  endtask

  initial begin
    test_reset();
    test_single_request();
    test_round_robin();
    test_begin_timeout();
    test_hang_abort();
    test_withdraw();
    test_reset_mid_active();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter sharing the single burst bus between up to `NUM_REQ` masters: the DMA custom-instruction engine, the CPU instruction/data caches and other bus masters. It grants one requester per transaction, tracks the begin/end transaction handshake on the shared bus and releases the bus afterwards. A watchdog recovers from masters that never begin, or slaves that never end, a transaction. It sits between the masters' `requestTransaction`/`transactionGranted` pairs and the shared bus signals.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BEGIN_TIMEOUT`, 16: cycles a granted master may take to assert `beginTransactionIn`.
- `END_TIMEOUT`, 1024: maximum cycles from begin to end before forced abort; power of two.

- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-low; `reset==0` at a rising edge resets the block.
- `requestTransaction`  in  NUM_REQ: one bit per master; level, held until granted.
- `transactionGranted`  out  NUM_REQ: registered one-hot grant, or all zero.
- `beginTransactionIn`  in  1: OR of all masters' begin strobes.
- `endTransactionIn`  in  1: end strobe from the bus, slave or master.
- `endTransactionOut`  out  1: one-cycle forced end on watchdog abort.
- `busErrorOut`  out  1: one-cycle error strobe on watchdog abort.
- `busIdle`  out  1: high when no grant is outstanding.
- `grantedId`  out  3: index of current or last grantee.

## Operation
- States:
  - `IDLE`: no grant outstanding.
  - `GRANTED`: grant issued, waiting for `beginTransactionIn`.
  - `ACTIVE`: transaction running, waiting for `endTransactionIn`.
  - `RELEASE`: one-cycle bus turnaround.
- Arbitration runs in `IDLE` and `RELEASE`.
  - Winner is the first set request bit at or after `prioPtr`, in increasing index order with wrap-around.
  - On a grant, `prioPtr <= winner+1` mod `NUM_REQ`.
- Transitions:
  - `IDLE` → `GRANTED` when any request is set.
  - `GRANTED` → `ACTIVE` on `beginTransactionIn`.
  - `GRANTED` → `IDLE` if the grantee drops its request, or on `BEGIN_TIMEOUT` expiry. Grant is withdrawn and no error is raised.
  - `ACTIVE` → `RELEASE` on `endTransactionIn`.
  - `ACTIVE` → `RELEASE` on `END_TIMEOUT` expiry. `endTransactionOut` and `busErrorOut` pulse for one cycle.
  - `RELEASE` → `GRANTED` if any request is set, else `IDLE`.
- In `ACTIVE`, the grant is held even if the grantee drops its request. Only an end or an abort releases the bus.
- `beginTransactionIn` outside `GRANTED` is ignored. `endTransactionIn` outside `ACTIVE` is ignored.
- If `beginTransactionIn` and `endTransactionIn` arrive in the same `GRANTED` cycle, the transaction is zero-length: the next state is `RELEASE`.
- If `endTransactionIn` and watchdog expiry coincide, `endTransactionIn` wins and no error is raised.
- Watchdog counter:
  - Width `$clog2(END_TIMEOUT)`.
  - Cleared on every state change.
  - Increments in `GRANTED` and `ACTIVE`.
  - Expiry is when count == timeout−1.
- Reset values: `transactionGranted=0`, `endTransactionOut=0`, `busErrorOut=0`, `busIdle=1`, `grantedId=0`, `prioPtr=0`, state `IDLE`, counter 0.
- Reset mid-transaction: all grants drop at that edge. No forced end is emitted.

## Timing
- Request first sampled at edge t in `IDLE` → `transactionGranted` high after edge t. Latency is 1 cycle.
- `endTransactionIn` sampled at edge e:
  - Grant low after e (`RELEASE`).
  - Next grant high after e+1.
  - Minimum gap between back-to-back grants: one cycle.
- `busIdle` is registered and follows state with the same timing as the grant.
- Forced-end strobes are high for exactly one cycle, in the cycle after expiry is detected.
- Fairness: with all masters requesting continuously, each master waits at most `NUM_REQ−1` transactions.

## Structure
- `bus_arbiter_pkg` holds:
  - state enum (`IDLE`, `GRANTED`, `ACTIVE`, `RELEASE`);
  - `MAX_REQ=8`;
  - `BEGIN_TIMEOUT` and `END_TIMEOUT` defaults;
  - grant-index width constant.
- Sub-module `rr_priority_picker`: combinational rotate/priority-encode over `NUM_REQ` bits.
  - Inputs: requests and `prioPtr`.
  - Outputs: one-hot winner, winner index and valid.

## Test plan
- Single request:
  - Stimulus: `requestTransaction=4'b0100` at t; begin at t+2, end at t+6.
  - Response: grant `0100` from t+1 through t+6, low at t+7, `busIdle=1` at t+8, `grantedId=2`.
- Round-robin:
  - Stimulus: all four requesting continuously; each transaction is 3 cycles.
  - Response: grant order 0,1,2,3,0; one-cycle grant gap between transactions.
- No-begin timeout:
  - Stimulus: master 1 granted and never begins.
  - Response: grant drops after 16 cycles, no `busErrorOut`, master 2 granted next when requesting.
- Hang abort:
  - Stimulus: begin, then no end for 1024 cycles.
  - Response: `endTransactionOut=1` and `busErrorOut=1` for exactly one cycle, grant released, `prioPtr` advanced.
- Request withdrawal:
  - Stimulus: grantee drops its request in `GRANTED`.
  - Response: grant low next cycle, `IDLE`.
  - Stimulus: grantee drops its request in `ACTIVE`.
  - Response: grant held until `endTransactionIn`.
- Reset mid-`ACTIVE`:
  - Stimulus: `reset=0` for one edge during `ACTIVE`.
  - Response: all outputs at reset values after that edge; a subsequent request from 3 is granted normally, with pointer restarting from 0.
